// File: rtl/mem_ldst.sv
// mem_ldst: load/store front end for spram32_32k; define LDST_UNALIGNED_EN to run word-crossing accesses as two SPRAM accesses
module mem_ldst #(
  parameter int AW = 17,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_sz,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          mem_we,
  output logic [3:0]    mem_bmsk,
  output logic [AW-3:0] mem_a,
  output logic [DW-1:0] mem_vi,
  input  logic [DW-1:0] mem_vo
);
`ifdef LDST_UNALIGNED_EN
  typedef enum logic [2:0] {IDLE, ISS1, CAP1, ISS2, CAP2, RSP} state_t;
`else
  typedef enum logic [2:0] {IDLE, ISS1, CAP1, RSP} state_t;
`endif
  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic [1:0]    sz_q, sz_d;
  logic [1:0]    off_q, off_d;
  logic          mem_we_q, mem_we_d;
  logic [3:0]    mem_bmsk_q, mem_bmsk_d;
  logic [AW-3:0] mem_a_q, mem_a_d;
  logic [DW-1:0] mem_vi_q, mem_vi_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
`ifdef LDST_UNALIGNED_EN
  logic          split_q, split_d;
  logic [3:0]    hmsk_q, hmsk_d;
  logic [DW-1:0] w1_q, w1_d;
`endif
  logic [7:0]    lanes_in, mask_in;
  logic          split_in, err_in;
  logic [DW-1:0] rot_in;
  logic [DW-1:0] lo, algn, keep, rdata;

  // decode the incoming request: lane mask over two words, split/error, lane-rotated store data
  always_comb begin
    lanes_in = (req_sz == 2'd0) ? 8'h01 : (req_sz == 2'd1) ? 8'h03 : 8'h0F;
    mask_in  = lanes_in << req_addr[1:0];
    split_in = |mask_in[7:4];
`ifdef LDST_UNALIGNED_EN
    err_in   = req_sz == 2'd3;
`else
    err_in   = (req_sz == 2'd3) | split_in;
`endif
    rot_in   = (req_addr[1:0] == 2'd0) ? req_wdata :
               (req_addr[1:0] == 2'd1) ? {req_wdata[23:0], req_wdata[31:24]} :
               (req_addr[1:0] == 2'd2) ? {req_wdata[15:0], req_wdata[31:16]} :
                                         {req_wdata[7:0],  req_wdata[31:8]};
  end

  // right-align read data: low word is the first captured word, high word is the live SPRAM output
  always_comb begin
`ifdef LDST_UNALIGNED_EN
    lo    = (state_q == CAP2) ? w1_q : mem_vo;
`else
    lo    = mem_vo;
`endif
    algn  = (off_q == 2'd0) ? lo :
            (off_q == 2'd1) ? {mem_vo[7:0],  lo[31:8]} :
            (off_q == 2'd2) ? {mem_vo[15:0], lo[31:16]} :
                              {mem_vo[23:0], lo[31:24]};
    keep  = (sz_q == 2'd0) ? 32'h0000_00FF : (sz_q == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    rdata = we_q ? '0 : (algn & keep);
  end

  // sequencer: next state and the registered SPRAM/response outputs for that state
  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    sz_d        = sz_q;
    off_d       = off_q;
    mem_we_d    = 1'b0;
    mem_bmsk_d  = 4'h0;
    mem_a_d     = mem_a_q;
    mem_vi_d    = mem_vi_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
`ifdef LDST_UNALIGNED_EN
    split_d     = split_q;
    hmsk_d      = hmsk_q;
    w1_d        = w1_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          sz_d     = req_sz;
          off_d    = req_addr[1:0];
          mem_a_d  = req_addr[AW-1:2];
          mem_vi_d = rot_in;
`ifdef LDST_UNALIGNED_EN
          split_d  = split_in;
          hmsk_d   = mask_in[7:4];
`endif
          if (err_in) begin
            state_d     = RSP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d    = ISS1;
            mem_we_d   = req_we;
            mem_bmsk_d = req_we ? mask_in[3:0] : 4'h0;
          end
        end
      end
      ISS1: state_d = CAP1;
      CAP1: begin
`ifdef LDST_UNALIGNED_EN
        w1_d = mem_vo;
        if (split_q) begin
          state_d    = ISS2;
          mem_we_d   = we_q;
          mem_bmsk_d = we_q ? hmsk_q : 4'h0;
          mem_a_d    = mem_a_q + {{(AW-3){1'b0}}, 1'b1};
        end else begin
          state_d     = RSP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = rdata;
        end
`else
        state_d     = RSP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = rdata;
`endif
      end
`ifdef LDST_UNALIGNED_EN
      ISS2: state_d = CAP2;
      CAP2: begin
        state_d     = RSP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = rdata;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // state and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      sz_q        <= 2'd0;
      off_q       <= 2'd0;
      mem_we_q    <= 1'b0;
      mem_bmsk_q  <= 4'h0;
      mem_a_q     <= '0;
      mem_vi_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
`ifdef LDST_UNALIGNED_EN
      split_q     <= 1'b0;
      hmsk_q      <= 4'h0;
      w1_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      sz_q        <= sz_d;
      off_q       <= off_d;
      mem_we_q    <= mem_we_d;
      mem_bmsk_q  <= mem_bmsk_d;
      mem_a_q     <= mem_a_d;
      mem_vi_q    <= mem_vi_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
`ifdef LDST_UNALIGNED_EN
      split_q     <= split_d;
      hmsk_q      <= hmsk_d;
      w1_q        <= w1_d;
`endif
    end
  end

  // write enable is cut the moment reset asserts so an in-flight store cannot land
  assign mem_we    = mem_we_q & rst_n;
  assign req_ready = (state_q == IDLE) & rst_n;
  assign mem_bmsk  = mem_bmsk_q;
  assign mem_a     = mem_a_q;
  assign mem_vi    = mem_vi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_mem_ldst.sv
// tb_mem_ldst: randomized bench for mem_ldst against a byte-addressed reference memory and per-cycle expectations
module tb_mem_ldst;
`ifdef LDST_UNALIGNED_EN
  localparam bit UNAL = 1'b1;
`else
  localparam bit UNAL = 1'b0;
`endif
  logic        clk, rst_n, req_valid, req_ready, req_we;
  logic [1:0]  req_sz;
  logic [16:0] req_addr;
  logic [31:0] req_wdata, rsp_rdata, mem_vi, mem_vo, nw;
  logic        rsp_valid, rsp_err, mem_we;
  logic [3:0]  mem_bmsk;
  logic [14:0] mem_a;

  mem_ldst #(.AW(17), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_sz(req_sz), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_we(mem_we), .mem_bmsk(mem_bmsk), .mem_a(mem_a), .mem_vi(mem_vi), .mem_vo(mem_vo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic        busy;
    logic        v;
    logic        err;
    logic [31:0] data;
    logic        mem;
    logic        we;
    logic [3:0]  bmsk;
    logic [14:0] a;
    logic [31:0] vi;
  } exp_t;

  exp_t        sched [int];
  exp_t        ce;
  logic [31:0] spram [0:32767];
  logic [7:0]  ref_b [0:131071];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  bit          chk_on = 1'b0;
  logic [31:0] d_rd, d_v1;
  logic        d_er;
  logic [14:0] d_a1, d_a2;
  logic [3:0]  d_m1, d_m2;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    nw = spram[mem_a];
    for (int k = 0; k < 4; k++) if (mem_bmsk[k]) nw[8*k +: 8] = mem_vi[8*k +: 8];
  end

  always @(posedge clk) begin
    if (mem_we) spram[mem_a] <= nw;
    mem_vo <= spram[mem_a];
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      if (sched.exists(cyc)) ce = sched[cyc];
      else ce = '0;
      chk("req_ready", {31'b0, req_ready}, {31'b0, !ce.busy});
      chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, ce.v});
      chk("rsp_err", {31'b0, rsp_err}, {31'b0, ce.err});
      chk("rsp_rdata", rsp_rdata, ce.data);
      chk("mem_we", {31'b0, mem_we}, {31'b0, ce.mem & ce.we});
      if (ce.mem) begin
        chk("mem_a", {17'b0, mem_a}, {17'b0, ce.a});
        chk("mem_bmsk", {28'b0, mem_bmsk}, {28'b0, ce.bmsk});
        chk("mem_vi", mem_vi, ce.vi);
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic [16:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er, output logic [14:0] a1, output logic [3:0] m1,
                       output logic [31:0] v1, output logic [14:0] a2, output logic [3:0] m2);
    int n, o, lat, acc, b;
    bit split, err;
    logic [31:0] mrd, vi;
    logic [7:0] m8;
    exp_t e;
    n = 1 << sz;
    o = int'(addr[1:0]);
    split = (sz != 2'd3) && (o + n > 4);
    err = (sz == 2'd3) || (split && !UNAL);
    lat = err ? 1 : split ? 5 : 3;
    mrd = '0;
    m8 = '0;
    vi = '0;
    for (int k = 0; k < 4; k++) vi[8*((o + k) % 4) +: 8] = wd[8*k +: 8];
    if (!err) begin
      for (int i = 0; i < n; i++) begin
        b = int'((addr + 17'(i)) & 17'h1FFFF);
        if (we) ref_b[b] = wd[8*i +: 8];
        else mrd[8*i +: 8] = ref_b[b];
        m8[o + i] = 1'b1;
      end
    end
    @(negedge clk);
    acc = cyc;
    req_valid = 1'b1; req_we = we; req_sz = sz; req_addr = addr; req_wdata = wd;
    for (int c = 1; c <= lat; c++) begin
      e = '0;
      e.busy = 1'b1;
      if (!err && (c == 1 || (split && c == 3))) begin
        e.mem = 1'b1;
        e.we = we;
        e.a = (c == 1) ? addr[16:2] : addr[16:2] + 15'd1;
        e.bmsk = !we ? 4'h0 : (c == 1) ? m8[3:0] : m8[7:4];
        e.vi = vi;
      end
      if (c == lat) begin
        e.v = 1'b1;
        e.err = err;
        e.data = (we || err) ? 32'h0 : mrd;
      end
      sched[acc + c] = e;
    end
    a2 = '0; m2 = '0; a1 = '0; m1 = '0; v1 = '0; rd = '0; er = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      req_valid = 1'($urandom_range(0, 1)); req_we = 1'($urandom_range(0, 1));
      req_sz = 2'($urandom_range(0, 3)); req_addr = 17'($urandom); req_wdata = $urandom;
      if (c == 1) begin a1 = mem_a; m1 = mem_bmsk; v1 = mem_vi; end
      if (c == 3) begin a2 = mem_a; m2 = mem_bmsk; end
      if (c == lat) begin rd = rsp_rdata; er = rsp_err; end
    end
    req_valid = 1'b0;
  endtask

  task automatic rst_mid(input logic [16:0] addr, input logic [31:0] wd, input int at);
    chk_on = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_sz = 2'd2; req_addr = addr; req_wdata = wd;
    for (int c = 1; c <= at; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
    chk("rst_ready_low", {31'b0, req_ready}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_ready_after", {31'b0, req_ready}, 32'h1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rst_no_rsp", {31'b0, rsp_valid}, 32'h0);
    end
    if (at > 1)
      for (int i = 0; i < 4 - int'(addr[1:0]); i++) ref_b[int'(addr) + i] = wd[8*i +: 8];
    sched.delete();
    chk_on = 1'b1;
  endtask

  initial begin
    int r;
    for (int w = 0; w < 32768; w++) begin
      spram[w] = $urandom;
      for (int k = 0; k < 4; k++) ref_b[4*w + k] = spram[w][8*k +: 8];
    end
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_sz = 2'd0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    chk("reset_rsp_err", {31'b0, rsp_err}, 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_mem_we", {31'b0, mem_we}, 32'h0);
    chk("reset_mem_bmsk", {28'b0, mem_bmsk}, 32'h0);
    chk("reset_mem_a", {17'b0, mem_a}, 32'h0);
    chk("reset_mem_vi", mem_vi, 32'h0);
    chk("reset_ready_low", {31'b0, req_ready}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", {31'b0, req_ready}, 32'h1);
    chk_on = 1'b1;

    issue(1'b1, 2'd2, 17'h00010, 32'hDEADBEEF, d_rd, d_er, d_a1, d_m1, d_v1, d_a2, d_m2);
    chk("st_word_a", {17'b0, d_a1}, 32'h4);
    chk("st_word_bmsk", {28'b0, d_m1}, 32'hF);
    issue(1'b0, 2'd2, 17'h00010, 32'h0, d_rd, d_er, d_a1, d_m1, d_v1, d_a2, d_m2);
    chk("ld_word", d_rd, 32'hDEADBEEF);
    issue(1'b1, 2'd2, 17'h00010, 32'h11223344, d_rd, d_er, d_a1, d_m1, d_v1, d_a2, d_m2);
    issue(1'b1, 2'd0, 17'h00013, 32'h0000005A, d_rd, d_er, d_a1, d_m1, d_v1, d_a2, d_m2);
    chk("st_byte_bmsk", {28'b0, d_m1}, 32'h8);
    chk("st_byte_vi", d_v1, 32'h5A000000);
    issue(1'b0, 2'd2, 17'h00010, 32'h0, d_rd, d_er, d_a1, d_m1, d_v1, d_a2, d_m2);
    chk("ld_word_merged", d_rd, 32'h5A223344);
    issue(1'b0, 2'd0, 17'h00012, 32'h0, d_rd, d_er, d_a1, d_m1, d_v1, d_a2, d_m2);
    chk("ld_byte", d_rd, 32'h00000022);
    issue(1'b1, 2'd3, 17'h00040, 32'h12345678, d_rd, d_er, d_a1, d_m1, d_v1, d_a2, d_m2);
    chk("sz3_err", {31'b0, d_er}, 32'h1);
    chk("sz3_rdata", d_rd, 32'h0);
`ifdef LDST_UNALIGNED_EN
    issue(1'b1, 2'd2, 17'h00005, 32'hAABBCCDD, d_rd, d_er, d_a1, d_m1, d_v1, d_a2, d_m2);
    chk("ua_a1", {17'b0, d_a1}, 32'h1);
    chk("ua_m1", {28'b0, d_m1}, 32'hE);
    chk("ua_v1", d_v1, 32'hBBCCDDAA);
    chk("ua_a2", {17'b0, d_a2}, 32'h2);
    chk("ua_m2", {28'b0, d_m2}, 32'h1);
    issue(1'b0, 2'd2, 17'h00005, 32'h0, d_rd, d_er, d_a1, d_m1, d_v1, d_a2, d_m2);
    chk("ua_ld", d_rd, 32'hAABBCCDD);
    issue(1'b1, 2'd1, 17'h1FFFF, 32'h0000BEEF, d_rd, d_er, d_a1, d_m1, d_v1, d_a2, d_m2);
    chk("wrap_a1", {17'b0, d_a1}, 32'h7FFF);
    chk("wrap_m1", {28'b0, d_m1}, 32'h8);
    chk("wrap_a2", {17'b0, d_a2}, 32'h0);
    chk("wrap_m2", {28'b0, d_m2}, 32'h1);
    issue(1'b0, 2'd1, 17'h1FFFF, 32'h0, d_rd, d_er, d_a1, d_m1, d_v1, d_a2, d_m2);
    chk("wrap_ld", d_rd, 32'h0000BEEF);
`else
    issue(1'b1, 2'd2, 17'h00002, 32'hCAFEF00D, d_rd, d_er, d_a1, d_m1, d_v1, d_a2, d_m2);
    chk("split_err", {31'b0, d_er}, 32'h1);
    chk("split_rdata", d_rd, 32'h0);
`endif

    for (int t = 0; t < 400; t++) begin
      r = $urandom_range(0, 3);
      req_addr = (r == 2) ? 17'($urandom) : (r == 1) ? 17'h1FFE0 + 17'($urandom_range(0, 31)) : 17'($urandom_range(0, 31));
      r = $urandom_range(0, 9);
      issue(1'($urandom_range(0, 1)), (r < 9) ? 2'(r % 3) : 2'd3, req_addr, $urandom,
            d_rd, d_er, d_a1, d_m1, d_v1, d_a2, d_m2);
      repeat ($urandom_range(0, 1)) @(negedge clk);
    end

`ifdef LDST_UNALIGNED_EN
    rst_mid(17'h00007, 32'h99887766, 3);
    issue(1'b0, 2'd2, 17'h00004, 32'h0, d_rd, d_er, d_a1, d_m1, d_v1, d_a2, d_m2);
    chk("rst_lane3", {24'b0, d_rd[31:24]}, 32'h66);
    issue(1'b0, 2'd2, 17'h00008, 32'h0, d_rd, d_er, d_a1, d_m1, d_v1, d_a2, d_m2);
`else
    rst_mid(17'h00020, 32'h99887766, 1);
    issue(1'b0, 2'd2, 17'h00020, 32'h0, d_rd, d_er, d_a1, d_m1, d_v1, d_a2, d_m2);
`endif
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
